gray_burst_arbiter: RTL and testbench
=====================================

Name: gray_burst_arbiter

Overview:
- Shares one 3-bit gray-code step counter (Clk/Reset/En/Output/Overflow interface) between two requesters.
- Each requester asks for a burst of N steps. The block grants one requester at a time, round-robin.
- For each burst it clears the counter, drives En for exactly N cycles, then returns the final gray value and a wrap flag.
- Sits between the requesting control logic and the counter instance at the same hierarchy level.

Parameters:
STEP_W, 4, width of burst-length inputs; max burst = 2^STEP_W-1 steps
CNT_W, 3, width of counter value bus (fixed 3 for the current counter; kept as parameter for bus sizing only)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Req  input  2  per-requester burst request, level, held until Done
Len0  input  STEP_W  burst length for requester 0, sampled at grant
Len1  input  STEP_W  burst length for requester 1, sampled at grant
Gnt  output  2  one-hot grant, held from grant through DONE cycle
Busy  output  1  high in any state other than IDLE
Done  output  1  one-cycle pulse in DONE state
Res_Value  output  CNT_W  counter value captured in DONE, held until next DONE
Res_Wrap  output  1  counter Overflow captured in DONE, held until next DONE
Cnt_En  output  1  drives counter En
Cnt_Clr  output  1  drives counter synchronous Reset (active-high)
Cnt_Value  input  CNT_W  counter Output
Cnt_Overflow  input  1  counter Overflow (sticky until cleared)

Behaviour:
- Reset (Reset=0, async):
  - State=IDLE; Gnt, Busy, Done, Cnt_En, Cnt_Clr = 0.
  - Res_Value=0, Res_Wrap=0, remaining-step count=0.
  - Priority pointer=0 (requester 0 preferred).
- States: IDLE, CLEAR, RUN, DONE; registered one-hot or binary, encoding from the package.
- IDLE:
  - If Req!=0: pick a winner. On a single request, that requester wins. On Req=2'b11, the requester the pointer selects wins.
  - Set Gnt one-hot and latch the winner's Len into rem. Next state CLEAR.
  - If Req=0: stay in IDLE.
- CLEAR:
  - Cnt_Clr=1 for exactly 1 cycle. The counter returns to 000 with Overflow=0 at the next edge.
  - Next state: RUN if rem!=0, else DONE.
- RUN:
  - Cnt_En=1 every cycle; rem decrements each cycle.
  - Leave for DONE on the cycle where rem==1, so that exactly Len En-cycles are issued.
- DONE:
  - Cnt_En=0, Done=1, Gnt still asserted.
  - Res_Value<=Cnt_Value and Res_Wrap<=Cnt_Overflow at the end of this cycle.
  - Pointer moves to the other requester (the one just served becomes lowest priority). Next state IDLE; Gnt drops.
- Latency:
  - Req sampled in IDLE at edge k. Gnt is high from cycle k+1.
  - CLEAR at k+1, RUN at k+2..k+1+Len, DONE at k+2+Len.
  - Res_* are valid from cycle k+3+Len.
- Len=0: CLEAR then DONE directly. Res_Value=000, Res_Wrap=0.
- Wrap: the counter sequence is 000,001,011,010,110,111,101,100,000. Step 8 sets Overflow, and Overflow stays set for the rest of the burst. Res_Value corresponds to (Len mod 8) in that sequence.
- Req deasserted mid-burst: ignored; the burst runs to DONE. Len changes after grant are ignored.
- Back-to-back: a requester still asserting Req in IDLE after its DONE competes normally. With the other requester pending, the other wins (pointer moved).
- Min gap between bursts: 1 IDLE cycle.
- Cnt_En and Cnt_Clr are never high together.
- Async reset mid-burst: outputs drop immediately. The counter is not cleared by this block; the next burst's CLEAR re-initialises it.

Decomposition:
- Package gray_arb_pkg: state encodings (IDLE/CLEAR/RUN/DONE), default STEP_W/CNT_W constants, gray sequence constants for benches.
- One sub-module rr_arb2: 2-input round-robin picker with pointer register. Inputs Req and an update strobe (driven from DONE); output one-hot winner.

Test Plan:
- Reset then Req=01, Len0=3 -> Gnt=01 from cycle 1; Cnt_Clr 1 cycle; Cnt_En 3 cycles; Done pulse; Res_Value=010, Res_Wrap=0.
- Req=10, Len1=10 -> 10 En cycles; Res_Value=011, Res_Wrap=1.
- Req=11 held, Len0=2, Len1=1 -> grants alternate 01,10,01,...; Res_Value alternates 011,001; Done pulses separated by exactly 1 IDLE cycle.
- Req=01, Len0=0 -> CLEAR then DONE; Cnt_En never high; Res_Value=000, Res_Wrap=0.
- Len0=15, drop Req after grant and change Len0 to 1 -> still 15 En cycles; Res_Value=100, Res_Wrap=1.
- Assert Reset=0 in RUN -> Gnt, Busy, Cnt_En go 0 without waiting for a clock edge. After release, Req=11 -> requester 0 wins first.

Source files
------------

// File: rtl/gray_arb_pkg.sv
// Shared definitions for the gray-counter burst arbiter.
//   state_t   : controller state encoding (IDLE/CLEAR/RUN/DONE)
//   STEP_W_D  : default burst-length width
//   CNT_W_D   : default counter value width
//   GRAY_SEQ  : 3-bit gray step sequence, element i = value after i steps
package gray_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int STEP_W_D = 4;
  localparam int CNT_W_D  = 3;

  // Element 0 is the rightmost entry.
  localparam logic [7:0][2:0] GRAY_SEQ = {
    3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000
  };

endpackage

// File: rtl/gray_burst_arbiter_rr_arb2.sv
// Two-input round-robin picker.
//   clk, rst_n : clock, async active-low reset
//   req        : request vector
//   upd        : strobe, move the pointer away from the served requester
//   served     : one-hot requester just served (sampled with upd)
//   win        : one-hot winner, combinational from req and pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic [1:0] served,
  output logic [1:0] win
);

  logic ptr;  // 0: requester 0 preferred on contention

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= 1'b0;
    else if (upd) ptr <= served[0];  // served requester drops to lowest priority
  end

  always_comb begin
    win = req;
    if (req == 2'b11) win = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/gray_burst_arbiter.sv
// Shares one 3-bit gray step counter between two requesters. Each granted
// burst clears the counter, enables it for exactly Len cycles, then captures
// the final value and overflow flag.
//   Clk, Reset            : clock, async active-low reset
//   Req, Len0, Len1       : level requests and per-requester burst lengths
//   Gnt, Busy, Done       : one-hot grant, non-idle flag, end-of-burst pulse
//   Res_Value, Res_Wrap   : captured counter result, held until next burst
//   Cnt_En, Cnt_Clr       : counter enable and synchronous clear
//   Cnt_Value, Cnt_Overflow : counter outputs
module gray_burst_arbiter
  import gray_arb_pkg::*;
#(
  parameter int STEP_W = STEP_W_D,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        Req,
  input  logic [STEP_W-1:0] Len0,
  input  logic [STEP_W-1:0] Len1,
  output logic [1:0]        Gnt,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  Res_Value,
  output logic              Res_Wrap,
  output logic              Cnt_En,
  output logic              Cnt_Clr,
  input  logic [CNT_W-1:0]  Cnt_Value,
  input  logic              Cnt_Overflow
);

  state_t            state;
  logic [STEP_W-1:0] rem;
  logic [1:0]        win;

  rr_arb2 u_rr (
    .clk    (Clk),
    .rst_n  (Reset),
    .req    (Req),
    .upd    (state == S_DONE),
    .served (Gnt),
    .win    (win)
  );

  // All outputs are registered; each is set on the transition into the
  // state that owns it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      rem       <= '0;
      Gnt       <= 2'b00;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Res_Value <= '0;
      Res_Wrap  <= 1'b0;
      Cnt_En    <= 1'b0;
      Cnt_Clr   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Req != 2'b00) begin
            Gnt     <= win;
            rem     <= win[1] ? Len1 : Len0;
            Busy    <= 1'b1;
            Cnt_Clr <= 1'b1;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          Cnt_Clr <= 1'b0;
          if (rem != '0) begin
            Cnt_En <= 1'b1;
            state  <= S_RUN;
          end else begin
            Done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_RUN: begin
          rem <= rem - 1'b1;
          // Last enable cycle: leave so exactly Len enables are issued.
          if (rem == STEP_W'(1)) begin
            Cnt_En <= 1'b0;
            Done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          Res_Value <= Cnt_Value;
          Res_Wrap  <= Cnt_Overflow;
          Done      <= 1'b0;
          Gnt       <= 2'b00;
          Busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_burst_arbiter.sv
module tb_gray_burst_arbiter;
  import gray_arb_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [1:0] Req = 2'b00;
  logic [3:0] Len0 = '0, Len1 = '0;
  logic [1:0] Gnt;
  logic       Busy, Done, Res_Wrap, Cnt_En, Cnt_Clr;
  logic [2:0] Res_Value, Cnt_Value;
  logic       Cnt_Overflow;

  int n_chk = 0, n_pass = 0;

  gray_burst_arbiter #(.STEP_W(4), .CNT_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Len0(Len0), .Len1(Len1),
    .Gnt(Gnt), .Busy(Busy), .Done(Done), .Res_Value(Res_Value),
    .Res_Wrap(Res_Wrap), .Cnt_En(Cnt_En), .Cnt_Clr(Cnt_Clr),
    .Cnt_Value(Cnt_Value), .Cnt_Overflow(Cnt_Overflow)
  );

  always #5 Clk = ~Clk;

  // Behavioural gray step counter: sync clear, sticky overflow on step 8.
  logic [2:0] cidx = '0;
  logic       cov  = 1'b0;
  always @(posedge Clk) begin
    if (Cnt_Clr) begin
      cidx <= '0;
      cov  <= 1'b0;
    end else if (Cnt_En) begin
      cidx <= cidx + 3'd1;
      if (cidx == 3'd7) cov <= 1'b1;
    end
  end
  assign Cnt_Value    = GRAY_SEQ[cidx];
  assign Cnt_Overflow = cov;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Starts from IDLE with Req already driven; the next edge grants.
  task automatic burst(input string tag, input logic [1:0] egnt, input int len,
                       input logic [2:0] eval, input logic ewrap,
                       input bit drop_after_gnt, input bit drop_at_done);
    int en = 0, n = 0, both = 0;
    tick();
    chk({tag, " gnt"}, Gnt, egnt);
    chk({tag, " clr"}, Cnt_Clr, 1);
    chk({tag, " busy"}, Busy, 1);
    if (drop_after_gnt) begin
      Req  = 2'b00;
      Len0 = 4'd1;
    end
    while (!Done && n < 40) begin
      if (Cnt_En && Cnt_Clr) both++;
      if (Cnt_En) en++;
      tick();
      n++;
    end
    chk({tag, " done"}, Done, 1);
    chk({tag, " cycles"}, n, len + 1);
    chk({tag, " en_cnt"}, en, len);
    chk({tag, " en_clr_overlap"}, both, 0);
    chk({tag, " gnt_at_done"}, Gnt, egnt);
    chk({tag, " en_at_done"}, Cnt_En, 0);
    if (drop_at_done) Req = 2'b00;
    tick();
    chk({tag, " res_value"}, Res_Value, eval);
    chk({tag, " res_wrap"}, Res_Wrap, ewrap);
    chk({tag, " idle_busy"}, Busy, 0);
    chk({tag, " idle_gnt"}, Gnt, 0);
    chk({tag, " done_pulse"}, Done, 0);
  endtask

  initial begin
    tick(); tick();
    chk("rst gnt", Gnt, 0);
    chk("rst busy", Busy, 0);
    chk("rst done", Done, 0);
    chk("rst en", Cnt_En, 0);
    chk("rst clr", Cnt_Clr, 0);
    chk("rst res", {Res_Wrap, Res_Value}, 0);
    @(negedge Clk);
    Reset = 1'b1;

    // Single requester, short burst.
    Req = 2'b01; Len0 = 4'd3;
    burst("r0_len3", 2'b01, 3, 3'b010, 1'b0, 0, 1);

    // Wrapping burst from requester 1.
    Req = 2'b10; Len1 = 4'd10;
    burst("r1_len10", 2'b10, 10, 3'b011, 1'b1, 0, 1);

    // Contention: pointer was moved away from 1, so 0 first, then alternate.
    Req = 2'b11; Len0 = 4'd2; Len1 = 4'd1;
    burst("alt0", 2'b01, 2, 3'b011, 1'b0, 0, 0);
    burst("alt1", 2'b10, 1, 3'b001, 1'b0, 0, 0);
    burst("alt2", 2'b01, 2, 3'b011, 1'b0, 0, 1);

    // Zero-length burst.
    Req = 2'b01; Len0 = 4'd0;
    burst("len0", 2'b01, 0, 3'b000, 1'b0, 0, 1);

    // Req and Len changed after grant are ignored.
    Req = 2'b01; Len0 = 4'd15;
    burst("len15_drop", 2'b01, 15, 3'b100, 1'b1, 1, 0);

    // Async reset mid-RUN; pointer currently prefers requester 1.
    Req = 2'b01; Len0 = 4'd6;
    tick(); tick(); tick();
    chk("pre_rst en", Cnt_En, 1);
    Reset = 1'b0;
    #2;
    chk("async gnt", Gnt, 0);
    chk("async busy", Busy, 0);
    chk("async en", Cnt_En, 0);
    @(negedge Clk);
    Reset = 1'b1;
    Req = 2'b11; Len0 = 4'd9; Len1 = 4'd4;
    burst("post_rst", 2'b01, 9, 3'b001, 1'b1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
